// File: rtl/ir_fetch_unit_if.sv
// rtl/ir_fetch_unit_if.sv - program memory bus and instruction issue handshake
interface ir_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 4
);
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_rd;
  logic [DATA_W-1:0]       mem_data;
  logic [DATA_W-1:0]       ir;
  logic [OPC_W-1:0]        opcode;
  logic [DATA_W-OPC_W-1:0] operand;
  logic                    ir_valid;
  logic                    ir_ready;

  // fetch unit side: drives the memory request and offers the instruction
  modport master (
    output mem_addr, mem_rd, ir, opcode, operand, ir_valid,
    input  mem_data, ir_ready
  );

  // memory / execute side
  modport slave (
    input  mem_addr, mem_rd, ir, opcode, operand, ir_valid,
    output mem_data, ir_ready
  );
endinterface

// File: rtl/ir_fetch_unit.sv
// rtl/ir_fetch_unit.sv - instruction fetch/issue stage behind the program counter
module ir_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int OPC_W   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              ir_clr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              refetch,
  ir_fetch_unit_if.master   bus,
  output logic              busy,
  output logic [7:0]        issue_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, ISSUE} state_t;

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  state_t            state;
  logic [ADDR_W-1:0] last_pc;
  logic              have_pc;
  logic [2:0]        lat_cnt;
  logic              refetch_pend;
  logic              pc_moved;
  logic              trigger;

  // A fetch is due on the first edge after reset, on any pc change, or on a refetch request
  assign pc_moved = (pc != last_pc);
  assign trigger  = !have_pc | pc_moved | refetch | refetch_pend;

  assign bus.opcode  = bus.ir[DATA_W-1 -: OPC_W];
  assign bus.operand = bus.ir[DATA_W-OPC_W-1:0];
  assign busy        = (state != IDLE);

  // Fetch/issue sequencer; runs on the falling edge in step with the PC stage
  always_ff @(negedge clk or negedge ir_clr) begin
    if (!ir_clr) begin
      state        <= IDLE;
      bus.ir       <= '0;
      bus.ir_valid <= 1'b0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      issue_cnt    <= 8'd0;
      last_pc      <= '0;
      have_pc      <= 1'b0;
      lat_cnt      <= 3'd0;
      refetch_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state        <= FETCH;
            bus.mem_addr <= pc;
            last_pc      <= pc;
            have_pc      <= 1'b1;
            bus.mem_rd   <= 1'b1;
            lat_cnt      <= 3'd0;
            refetch_pend <= 1'b0;
          end
        end
        FETCH: begin
          if (refetch) refetch_pend <= 1'b1;
          // a moving pc makes the in-flight read stale, so restart on the new address
          if (pc_moved) begin
            bus.mem_addr <= pc;
            last_pc      <= pc;
            lat_cnt      <= 3'd0;
          end else if (lat_cnt == LAT_LAST) begin
            state      <= LATCH;
            bus.mem_rd <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        LATCH: begin
          if (refetch) refetch_pend <= 1'b1;
          bus.ir       <= bus.mem_data;
          bus.ir_valid <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          if (bus.ir_ready) begin
            bus.ir_valid <= 1'b0;
            issue_cnt    <= issue_cnt + 8'd1;
            // go straight back to fetching if pc moved or a refetch is outstanding
            if (trigger) begin
              state        <= FETCH;
              bus.mem_addr <= pc;
              last_pc      <= pc;
              have_pc      <= 1'b1;
              bus.mem_rd   <= 1'b1;
              lat_cnt      <= 3'd0;
              refetch_pend <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (refetch) begin
            refetch_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// tb/tb_ir_fetch_unit.sv - directed bench for ir_fetch_unit at memory latency 1 and 3
module tb_ir_fetch_unit;

  logic       clk;
  logic       ir_clr;
  logic [7:0] pc;
  logic       refetch;
  logic       busy1, busy3;
  logic [7:0] cnt1, cnt3;
  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;
  logic [7:0] exp1;

  ir_fetch_unit_if #(.ADDR_W(8), .DATA_W(16), .OPC_W(4)) b1 ();
  ir_fetch_unit_if #(.ADDR_W(8), .DATA_W(16), .OPC_W(4)) b3 ();

  assign b1.mem_data = mem[b1.mem_addr];
  assign b3.mem_data = mem[b3.mem_addr];

  ir_fetch_unit #(.ADDR_W(8), .DATA_W(16), .OPC_W(4), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .ir_clr(ir_clr), .pc(pc), .refetch(refetch),
    .bus(b1.master), .busy(busy1), .issue_cnt(cnt1)
  );

  ir_fetch_unit #(.ADDR_W(8), .DATA_W(16), .OPC_W(4), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .ir_clr(ir_clr), .pc(pc), .refetch(refetch),
    .bus(b3.master), .busy(busy3), .issue_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    @(posedge clk);
    for (int n = 0; n < 60 && (busy1 || busy3); n++) @(posedge clk);
    check("idle_timeout", {31'd0, busy1 | busy3}, 32'd0);
  endtask

  task automatic wait_valid1();
    @(posedge clk);
    for (int n = 0; n < 60 && !b1.ir_valid; n++) @(posedge clk);
    check("valid_timeout", {31'd0, b1.ir_valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hA005;
    mem[8'h02] = 16'h7ABC;
    mem[8'h05] = 16'h5555;
    mem[8'h09] = 16'h9999;
    mem[8'h10] = 16'hBEEF;
    mem[8'h11] = 16'h5A5A;
    mem[8'h20] = 16'hC0DE;
    mem[8'h30] = 16'h4321;

    ir_clr = 1'b0;
    pc = 8'h00;
    refetch = 1'b0;
    b1.ir_ready = 1'b1;
    b3.ir_ready = 1'b1;
    exp1 = 8'd0;

    // reset state
    repeat (2) @(posedge clk);
    check("rst_ir", b1.ir, 0);
    check("rst_valid", b1.ir_valid, 0);
    check("rst_rd", b1.mem_rd, 0);
    check("rst_addr", b1.mem_addr, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_busy", busy1, 0);

    // first fetch after release: valid on the third falling edge
    ir_clr = 1'b1;
    @(posedge clk);
    check("t1_busy", busy1, 1);
    check("t1_rd", b1.mem_rd, 1);
    check("t1_addr", b1.mem_addr, 8'h00);
    check("t1_valid_e1", b1.ir_valid, 0);
    @(posedge clk);
    check("t1_valid_e2", b1.ir_valid, 0);
    check("t1_rd_e2", b1.mem_rd, 0);
    @(posedge clk);
    check("t1_valid_e3", b1.ir_valid, 1);
    check("t1_ir", b1.ir, 16'h1234);
    check("t1_opcode", b1.opcode, 4'h1);
    check("t1_operand", b1.operand, 12'h234);
    check("t1_cnt_pre", cnt1, 0);
    @(posedge clk);
    exp1++;
    check("t1_cnt", cnt1, exp1);
    check("t1_valid_done", b1.ir_valid, 0);
    check("t1_idle", busy1, 0);
    check("t1_l3_valid_e4", b3.ir_valid, 0);
    @(posedge clk);
    check("t1_l3_valid_e5", b3.ir_valid, 1);
    check("t1_l3_ir", b3.ir, 16'h1234);
    wait_idle();

    // pc auto-increment: each word issued once, in order
    pc = 8'h01;
    wait_valid1();
    check("t2_ir1", b1.ir, 16'hA005);
    check("t2_opc1", b1.opcode, 4'hA);
    check("t2_opr1", b1.operand, 12'h005);
    wait_idle();
    exp1++;
    check("t2_cnt1", cnt1, exp1);
    pc = 8'h02;
    wait_valid1();
    check("t2_ir2", b1.ir, 16'h7ABC);
    wait_idle();
    exp1++;
    check("t2_cnt2", cnt1, exp1);
    repeat (6) @(posedge clk);
    check("t2_stable_busy", busy1, 0);
    check("t2_stable_cnt", cnt1, exp1);

    // pc change during a fetch aborts and restarts on the new address
    pc = 8'h05;
    @(posedge clk);
    check("t3_addr5", b3.mem_addr, 8'h05);
    check("t3_rd5", b3.mem_rd, 1);
    pc = 8'h09;
    @(posedge clk);
    check("t3_addr9", b3.mem_addr, 8'h09);
    check("t3_rd9", b3.mem_rd, 1);
    wait_idle();
    check("t3_l3_ir", b3.ir, 16'h9999);
    check("t3_l3_cnt", cnt3, 8'd4);
    exp1++;
    check("t3_l1_cnt", cnt1, exp1);
    check("t3_l1_ir", b1.ir, 16'h9999);

    // backpressure: offered word held while pc moves, new pc fetched after acceptance
    b1.ir_ready = 1'b0;
    pc = 8'h10;
    wait_valid1();
    check("t4_ir", b1.ir, 16'hBEEF);
    pc = 8'h11;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      check("t4_hold_valid", b1.ir_valid, 1);
      check("t4_hold_ir", b1.ir, 16'hBEEF);
    end
    check("t4_hold_cnt", cnt1, exp1);
    b1.ir_ready = 1'b1;
    @(posedge clk);
    exp1++;
    check("t4_acc_valid", b1.ir_valid, 0);
    check("t4_acc_cnt", cnt1, exp1);
    check("t4_acc_busy", busy1, 1);
    check("t4_acc_addr", b1.mem_addr, 8'h11);
    wait_idle();
    exp1++;
    check("t4_next_ir", b1.ir, 16'h5A5A);
    check("t4_next_cnt", cnt1, exp1);

    // refetch of a static pc, repeated until the issue counter wraps
    pc = 8'h20;
    wait_idle();
    exp1++;
    check("t5_first", b1.ir, 16'hC0DE);
    check("t5_first_cnt", cnt1, exp1);
    do begin
      @(posedge clk);
      refetch = 1'b1;
      @(posedge clk);
      refetch = 1'b0;
      wait_idle();
      exp1++;
      check("t5_ir", b1.ir, 16'hC0DE);
      check("t5_cnt", cnt1, exp1);
    end while (exp1 != 8'd0);
    check("t5_wrap", cnt1, 8'h00);

    // asynchronous reset while an instruction is offered
    b1.ir_ready = 1'b0;
    pc = 8'h30;
    wait_valid1();
    check("t6_ir_pre", b1.ir, 16'h4321);
    #2 ir_clr = 1'b0;
    #1;
    check("t6_rst_ir", b1.ir, 0);
    check("t6_rst_valid", b1.ir_valid, 0);
    check("t6_rst_rd", b1.mem_rd, 0);
    check("t6_rst_cnt", cnt1, 0);
    check("t6_rst_busy", busy1, 0);
    @(posedge clk);
    ir_clr = 1'b1;
    b1.ir_ready = 1'b1;
    @(posedge clk);
    check("t6_refetch_busy", busy1, 1);
    check("t6_refetch_addr", b1.mem_addr, 8'h30);
    check("t6_refetch_rd", b1.mem_rd, 1);
    wait_idle();
    check("t6_ir", b1.ir, 16'h4321);
    check("t6_cnt", cnt1, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
